// File: rtl/buffer_pkg.sv
// Shared definitions for the datapath buffer blocks: mode encoding and push/pop decode.
package buffer_pkg;

  localparam logic MODE_LIFO = 1'b0;
  localparam logic MODE_FIFO = 1'b1;

  // Request decode, indexed as {push, pop}
  typedef enum logic [1:0] {
    OpIdle    = 2'b00,
    OpPop     = 2'b01,
    OpPush    = 2'b10,
    OpPushPop = 2'b11
  } buf_op_e;

endpackage

// File: rtl/buffer_ram.sv
// DEPTH x B storage: one synchronous write port, one asynchronous read port.
module buffer_ram #(
  parameter int unsigned B = 8,
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] waddr,
  input  logic [B-1:0] wdata,
  input  logic [W-1:0] raddr,
  output logic [B-1:0] rdata
);

  logic [B-1:0] mem [2**W];

  // Write port; contents are never reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_fifo_buffer.sv
// Run-time selectable LIFO/FIFO buffer with occupancy count, almost-full and sticky error flags.
module lifo_fifo_buffer
  import buffer_pkg::*;
#(
  parameter int unsigned B        = 8,
  parameter int unsigned W        = 4,
  parameter int unsigned AF_LEVEL = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mode,
  input  logic         push,
  input  logic [B-1:0] push_data,
  input  logic         pop,
  output logic [B-1:0] pop_data,
  output logic [W:0]   count,
  output logic         empty,
  output logic         full,
  output logic         almost_full,
  output logic         mode_active,
  output logic         overflow,
  output logic         underflow,
  input  logic         clr_err
);

  localparam logic [W:0]   DepthCnt = {1'b1, {W{1'b0}}};
  localparam logic [W:0]   AfLevel  = (W+1)'(AF_LEVEL);
  localparam logic [W-1:0] PtrOne   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W:0]   CntOne   = {{W{1'b0}}, 1'b1};

  logic [W-1:0] wr_ptr_q, wr_ptr_d;
  logic [W-1:0] rd_ptr_q, rd_ptr_d;
  logic [W:0]   count_q, count_d;
  logic         mode_q, mode_d;
  logic         ovf_q, ovf_d;
  logic         unf_q, unf_d;

  logic         is_empty, is_full;
  logic         ram_we;
  logic [W-1:0] ram_waddr, ram_raddr;
  logic [B-1:0] ram_rdata;
  logic         ovf_set, unf_set;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DepthCnt);

  // Next-state decode for pointers, count, mode and error flags
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    mode_d    = mode_q;
    ram_we    = 1'b0;
    ram_waddr = wr_ptr_q;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;

    unique case (buf_op_e'({push, pop}))
      OpIdle: ;
      OpPush: begin
        if (is_full) begin
          ovf_set = 1'b1;
        end else begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PtrOne;
          count_d  = count_q + CntOne;
        end
      end
      OpPop: begin
        if (is_empty) begin
          unf_set = 1'b1;
        end else begin
          count_d = count_q - CntOne;
          if (mode_q == MODE_LIFO) begin
            wr_ptr_d = wr_ptr_q - PtrOne;
          end else begin
            rd_ptr_d = rd_ptr_q + PtrOne;
          end
        end
      end
      OpPushPop: begin
        if (is_empty) begin
          // Nothing to pop: behaves as a plain push, no underflow
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PtrOne;
          count_d  = count_q + CntOne;
        end else if (mode_q == MODE_LIFO) begin
          // Replace the top of stack in place
          ram_we    = 1'b1;
          ram_waddr = wr_ptr_q - PtrOne;
        end else begin
          // Both ends move; when full the popped slot is the one rewritten
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PtrOne;
          rd_ptr_d = rd_ptr_q + PtrOne;
        end
      end
      default: ;
    endcase

    if (is_empty && !push) begin
      mode_d = mode;
    end

    // A new error in the same cycle as clr_err wins
    ovf_d = (ovf_q & ~clr_err) | ovf_set;
    unf_d = (unf_q & ~clr_err) | unf_set;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mode_q   <= MODE_LIFO;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mode_q   <= mode_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign ram_raddr = (mode_q == MODE_LIFO) ? (wr_ptr_q - PtrOne) : rd_ptr_q;

  buffer_ram #(
    .B(B),
    .W(W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we && !reset),
    .waddr(ram_waddr),
    .wdata(push_data),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  assign pop_data    = is_empty ? '0 : ram_rdata;
  assign count       = count_q;
  assign empty       = is_empty;
  assign full        = is_full;
  assign almost_full = (count_q >= AfLevel);
  assign mode_active = mode_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule
